// File: rtl/aes_decryptor_if.sv
// Request/result bundle shared by the AES encryptor and decryptor.
interface aes_decryptor_if;
  logic         req;
  logic [0:127] data;
  logic [0:127] key;
  logic         busy;
  logic         done;
  logic [0:127] out_data;

  modport master (
    output req, data, key,
    input  busy, done, out_data
  );

  modport slave (
    input  req, data, key,
    output busy, done, out_data
  );
endinterface

// File: rtl/aes_decryptor.sv
// Iterative AES-128 inverse cipher, one round per clock. The cipher key is
// first expanded forward to round key 10; the inverse rounds then rebuild
// the earlier round keys backwards on the fly.
module aes_decryptor #(
  parameter int NR = 10
) (
  input logic          clk,
  input logic          rstN,
  aes_decryptor_if.slave bus
);

  localparam logic [3:0] NR_W = 4'(NR);

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_e;

  // ---------------------------------------------------------------------
  // GF(2^8) arithmetic and byte substitution
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, a);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, a);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, a);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, a);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, a);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  // ---------------------------------------------------------------------
  // Key schedule
  // ---------------------------------------------------------------------
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [0:31] sub_word(input logic [0:31] w);
    return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
  endfunction

  // Round key r from round key r-1.
  function automatic logic [0:127] get_round_key(input logic [0:127] rk,
                                                 input logic [3:0]   r);
    logic [0:31] w0, w1, w2, w3;
    w0 = rk[0:31] ^ sub_word({rk[104:127], rk[96:103]}) ^ {rcon(r), 24'h000000};
    w1 = rk[32:63] ^ w0;
    w2 = rk[64:95] ^ w1;
    w3 = rk[96:127] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Round key r-1 from round key r.
  function automatic logic [0:127] inv_round_key(input logic [0:127] rk,
                                                 input logic [3:0]   r);
    logic [0:31] w0, w1, w2, w3;
    w3 = rk[96:127] ^ rk[64:95];
    w2 = rk[64:95] ^ rk[32:63];
    w1 = rk[32:63] ^ rk[0:31];
    w0 = rk[0:31] ^ sub_word({w3[8:31], w3[0:7]}) ^ {rcon(r), 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  // ---------------------------------------------------------------------
  // Inverse round transforms (byte i -> row i%4, column i/4)
  // ---------------------------------------------------------------------
  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+4-r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                          gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[32*c + 8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                          gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                          gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                          gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e       fsm_q, fsm_d;
  logic [0:127] st_q, st_d;
  logic [0:127] rk_q, rk_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [0:127] out_data_q, out_data_d;
  logic [0:127] isb;

  // Shared front half of both the middle rounds and the last round.
  assign isb = inv_sub_bytes(inv_shift_rows(st_q));

  // Next-state and datapath updates for each phase of a decryption.
  always_comb begin
    fsm_d      = fsm_q;
    st_d       = st_q;
    rk_d       = rk_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    out_data_d = out_data_q;
    case (fsm_q)
      IDLE: begin
        if (bus.req) begin
          st_d  = bus.data;
          rk_d  = bus.key;
          cnt_d = 4'd1;
          fsm_d = KEYEXP;
        end
      end
      KEYEXP: begin
        rk_d  = get_round_key(rk_q, cnt_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == NR_W) fsm_d = INIT;
      end
      INIT: begin
        st_d  = st_q ^ rk_q;
        rk_d  = inv_round_key(rk_q, NR_W);
        cnt_d = NR_W - 4'd1;
        fsm_d = ROUND;
      end
      ROUND: begin
        st_d  = inv_mix_columns(isb ^ rk_q);
        rk_d  = inv_round_key(rk_q, cnt_q);
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        out_data_d = isb ^ rk_q;
        done_d     = 1'b1;
        fsm_d      = DONE;
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
    busy_d = (fsm_d != IDLE);
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fsm_q      <= IDLE;
      st_q       <= '0;
      rk_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      st_q       <= st_d;
      rk_q       <= rk_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_aes_decryptor.sv
// Bench for aes_decryptor: known-answer vectors, key schedule taps,
// collision/reset handling and a random round trip through a forward model.
module tb_aes_decryptor;

  localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK_C1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK_B   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic [127:0] exp;
    int           acc_edge;
  } sb_t;

  logic clk = 1'b0;
  logic rstN;
  aes_decryptor_if bus();

  aes_decryptor #(.NR(10)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         edge_n = 0;
  sb_t        sb_q[$];
  logic [7:0] sbox_t[256];
  bit         width_pending = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Forward S-box built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ {sbox_t[k[23:16]], sbox_t[k[15:8]], sbox_t[k[7:0]], sbox_t[k[31:24]]}
         ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Forward AES-128 cipher used to manufacture ciphertexts.
  function automatic logic [127:0] enc_model(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] st, rk, t;
    logic [7:0]   rc, a0, a1, a2, a3;
    st = pt ^ k;
    rk = k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = next_key(rk, rc);
      rc = xt(rc);
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = sbox_t[st[127-8*i -: 8]];
      t = st;
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[127-8*(4*c+w) -: 8] = st[127-8*(4*((c+w)%4)+w) -: 8];
      st = t;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[127-32*c -: 8];
          a1 = st[119-32*c -: 8];
          a2 = st[111-32*c -: 8];
          a3 = st[103-32*c -: 8];
          st[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      st = st ^ rk;
    end
    return st;
  endfunction

  // Result monitor: pops the scoreboard on done, checks data, latency and pulse width.
  always @(negedge clk) begin
    sb_t e;
    if (width_pending) begin
      check("done_width", bus.done, 1'b0);
      width_pending = 1'b0;
    end else if (bus.done) begin
      width_pending = 1'b1;
      if (sb_q.size() == 0) begin
        check("unexpected_done", bus.done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("out_data", bus.out_data, e.exp);
        check("latency", edge_n - e.acc_edge, 21);
      end
    end
  end

  task automatic start_op(input logic [127:0] ct, input logic [127:0] k,
                          input logic [127:0] exp, input bit track);
    @(negedge clk);
    bus.req  = 1'b1;
    bus.data = ct;
    bus.key  = k;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    if (track) sb_q.push_back('{exp: exp, acc_edge: edge_n});
    check("busy_after_accept", bus.busy, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", bus.busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          busy_cnt;
    int          acc;
    logic [127:0] pt, k;

    build_sbox();
    rstN     = 1'b1;
    bus.req  = 1'b0;
    bus.data = '0;
    bus.key  = '0;
    #2 rstN = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    @(negedge clk);
    rstN = 1'b1;

    // FIPS-197 C.1 with key schedule taps
    start_op(CT_C1, K_C1, PT_C1, 1'b1);
    repeat (10) @(posedge clk);
    #1 check("c1_rk10", dut.rk_q, RK_C1);
    repeat (10) @(posedge clk);
    #1 check("c1_rk0", dut.rk_q, K_C1);
    wait_idle();

    // FIPS-197 Appendix B
    start_op(CT_B, K_B, PT_B, 1'b1);
    repeat (10) @(posedge clk);
    #1 check("b_rk10", dut.rk_q, RK_B);
    wait_idle();

    // Request while busy must be ignored
    start_op(CT_C1, K_C1, PT_C1, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 4) begin
        bus.req  = 1'b1;
        bus.data = CT_B;
        bus.key  = K_B;
      end
      if (i == 5) bus.req = 1'b0;
      if (!bus.busy) break;
      busy_cnt++;
    end
    bus.req = 1'b0;
    check("busy_cycles", busy_cnt, 22);
    repeat (3) @(negedge clk);
    check("no_restart", bus.busy, 1'b0);

    // Reset mid-operation, then a fresh request
    start_op(CT_C1, K_C1, '0, 1'b0);
    repeat (12) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_out_data", bus.out_data, '0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_idle", bus.busy, 1'b0);
    start_op(CT_B, K_B, PT_B, 1'b1);
    wait_idle();

    // req held high: second operation starts 23 edges after the first
    @(negedge clk);
    bus.req  = 1'b1;
    bus.data = CT_C1;
    bus.key  = K_C1;
    @(posedge clk);
    #1;
    acc = edge_n;
    sb_q.push_back('{exp: PT_C1, acc_edge: acc});
    sb_q.push_back('{exp: PT_B, acc_edge: acc + 23});
    bus.data = CT_B;
    bus.key  = K_B;
    repeat (23) @(posedge clk);
    #1 bus.req = 1'b0;
    wait_idle();

    // Random round trip through the forward model
    for (int v = 0; v < 100; v++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      start_op(enc_model(pt, k), k, pt, 1'b1);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_decryptor.md
Name: aes_decryptor

Overview:
- Iterative AES-128 decryptor (FIPS-197 inverse cipher). Processes one round per clock.
- Input is a 128-bit ciphertext and the original cipher key. The block first expands the key forward to round key 10, then runs the inverse rounds while regenerating round keys backwards on the fly.
- Sits beside the AES encryptor behind the same req/data/key interface. Shares the AES_pkg state enum style.
- New package functions InvSubBytes, InvShiftRows, InvMixColumns and InvRoundKey are added to AES_pkg.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rstN  in  1  reset, asynchronous, active-low.
- req  in  1  start request; sampled only in IDLE.
- data  in  128 [0:127]  ciphertext; captured on the accepting edge.
- key  in  128 [0:127]  cipher key (round key 0); captured on the accepting edge.
- busy  out  1  high from the accepting edge until done deasserts.
- done  out  1  one-cycle pulse; out_data is valid.
- out_data  out  128 [0:127]  plaintext; holds its value until the next done.

Behaviour:
- Byte order: bit 0 is the MSB; byte i = bits [8i:8i+7]; byte i maps to row i%4, column i/4 (FIPS-197).
- Registers: st (128-bit state), rk (128-bit round key), cnt (4-bit), fsm.
- Reset (rstN=0, async): fsm=IDLE, st=0, rk=0, cnt=0, busy=0, done=0, out_data=0. Any in-flight operation is abandoned with no done pulse.
- IDLE: if req=1 at edge E0 then st<=data, rk<=key, cnt<=1, go to KEYEXP. If req=0, hold.
- KEYEXP (edges E1..E10): rk<=GetRoundKey(rk,cnt) (forward schedule, Rcon[cnt]), cnt<=cnt+1. Leave for INIT when cnt=10. After E10, rk=round key 10.
- INIT (E11):
  - st<=st^rk.
  - rk<=InvRoundKey(rk,10), cnt<=9.
- ROUND (E12..E20, cnt=9..1):
  - st<=InvMixColumns(InvSubBytes(InvShiftRows(st))^rk).
  - rk<=InvRoundKey(rk,cnt), cnt<=cnt-1.
  - Leave for FINAL when cnt=1.
- FINAL (E21):
  - out_data<=InvSubBytes(InvShiftRows(st))^rk, where rk = round key 0.
  - done<=1, go to DONE.
- DONE (E22): done<=0, busy<=0, go to IDLE.
- Latency: done is high between E21 and E22. That is 21 cycles from the accepting edge; next req is accepted at E23 at the earliest.
- InvRoundKey(w0..w3, r) produces w0'..w3':
  - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0.
  - w0'=w0^SubWord(RotWord(w3'))^{Rcon[r],00,00,00}.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36 for r=1..10.
- req while busy: ignored; no queuing. data/key changes while busy have no effect.
- req held high continuously: a new operation starts at every IDLE. Back-to-back period is 23 cycles.
- busy = (fsm != IDLE), registered.
- out_data is not updated outside FINAL.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, data=69c4e0d86a7b0430d8cdb78070b4c55a, req pulse -> done exactly 21 cycles after the accepting edge; out_data=00112233445566778899aabbccddeeff.
- FIPS-197 App B: key=2b7e151628aed2a6abf7158809cf4f3c, data=3925841d02dc09fbdc118597196a0b32 -> out_data=3243f6a8885a308d313198a2e0370734. Internal rk after E10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key schedule check: C.1 key -> rk after E10 = 13111d7fe3944a17f307a78b4d2b30c5; rk at FINAL = 000102030405060708090a0b0c0d0e0f.
- Busy collision: start C.1, pulse req with different data/key at cycle 5 -> single done, C.1 result, busy high for 22 cycles.
- Reset mid-op: assert rstN=0 at cycle 12 -> all outputs 0 immediately, no done. A fresh App B request after release -> correct result with 21-cycle latency.
- Round trip: encryptor output fed to decryptor with the same key, 100 random vectors -> out_data equals the original plaintext; done pulse width is exactly 1 cycle each time.
